// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified instruction/data memory arbiter:
// FSM state encoding, owner encoding and the reset value of the fetch word.
package mem_arb_pkg;

    // Arbiter FSM states; the encoding is fixed so it can be probed in debug.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    // Which requester owns the transaction being granted.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    // Byte-strobe width of every memory port.
    localparam int STRB_W = 4;

    // Fetch word presented before the first fetch completes (addi x0,x0,0).
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Request/ready memory port. The same bundle describes the CPU fetch port,
// the CPU data port and the downstream memory port; the side that issues
// requests uses the master modport.
interface unified_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    import mem_arb_pkg::*;

    logic                  req;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  we;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (
        output req, addr, wdata, wstrb, we,
        input  rdata, ready
    );

    modport slave (
        input  req, addr, wdata, wstrb, we,
        output rdata, ready
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Grant decision plus saturating starvation counter. Data wins a contested
// grant until STARVE_LIMIT data grants have been made while a fetch waited;
// the next contested grant then goes to fetch and the count restarts.
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic imem_req,
    input  logic dmem_req,
    input  logic grant_en,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       fetch_starved;

    // Decide who gets the memory when the arbiter is free to grant.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; assigning defaults first is what keeps latches from being inferred.
        fetch_starved = 1'b0;
        grant_d       = 1'b0;
        grant_i       = 1'b0;
        fetch_starved = imem_req && (starve_cnt >= LIMIT);
        grant_d       = grant_en && dmem_req && !fetch_starved;
        grant_i       = grant_en && imem_req && !grant_d;
    end

    // Count data grants that overtook a waiting fetch; any fetch grant clears.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && imem_req && (starve_cnt < LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Sequences one single-ported memory between the CPU fetch and data ports,
// one transaction at a time. All outputs are registered.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    unified_mem_arbiter_if.slave         imem,
    unified_mem_arbiter_if.slave         dmem,
    unified_mem_arbiter_if.master        mem,
    output logic [31:0]                  conflict_count
);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic                  grant_en;
    logic                  grant_i;
    logic                  grant_d;
    owner_e                grant_owner;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_wdata;
    logic [STRB_W-1:0]     grant_wstrb;
    logic                  grant_we;

    // The fetch port never writes; its write fields are deliberately dropped.
    logic unused_imem_fields;
    assign unused_imem_fields = ^{imem.wdata, imem.wstrb, imem.we};

    // Grants are only made from IDLE; requests in any other state wait.
    assign grant_en = (state_q == IDLE);

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .imem_req (imem.req),
        .dmem_req (dmem.req),
        .grant_en (grant_en),
        .grant_i  (grant_i),
        .grant_d  (grant_d)
    );

    // Select the fields latched downstream; a fetch always reads whole words.
    always_comb begin
        grant_owner = grant_d ? OWNER_D : OWNER_I;
        grant_addr  = (grant_owner == OWNER_D) ? dmem.addr  : imem.addr;
        grant_wdata = (grant_owner == OWNER_D) ? dmem.wdata : '0;
        grant_wstrb = (grant_owner == OWNER_D) ? dmem.wstrb : '0;
        grant_we    = (grant_owner == OWNER_D) && dmem.we;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant, wait for memory, respond for one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = BUSY_D;
                end else if (grant_i) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem.ready) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Downstream request, captured read data and one-cycle ready pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem.req    <= 1'b0;
            mem.we     <= 1'b0;
            mem.addr   <= '0;
            mem.wdata  <= '0;
            mem.wstrb  <= '0;
            imem.rdata <= DATA_WIDTH'(NOP_INSTR);
            dmem.rdata <= '0;
            imem.ready <= 1'b0;
            dmem.ready <= 1'b0;
        end else begin
            imem.ready <= 1'b0;
            dmem.ready <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_i || grant_d) begin
                        mem.req   <= 1'b1;
                        mem.addr  <= grant_addr;
                        mem.wdata <= grant_wdata;
                        mem.wstrb <= grant_wstrb;
                        mem.we    <= grant_we;
                    end
                end
                BUSY_I: begin
                    if (mem.ready) begin
                        mem.req    <= 1'b0;
                        imem.rdata <= mem.rdata;
                        imem.ready <= 1'b1;
                    end
                end
                BUSY_D: begin
                    if (mem.ready) begin
                        mem.req    <= 1'b0;
                        dmem.ready <= 1'b1;
                        if (!mem.we) begin
                            dmem.rdata <= mem.rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Count grants made while both requesters were waiting; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_count <= '0;
        end else if ((grant_i || grant_d) && imem.req && dmem.req) begin
            conflict_count <= conflict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: a latency-programmable memory
// model, requester agents, and scoreboards for downstream grants and for
// fetch/data completions.
module tb_unified_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        we;
    } grant_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] conflict_count;

    unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();
    unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dmem_bus ();
    unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_bus ();

    unified_mem_arbiter #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .STARVE_LIMIT (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .dmem           (dmem_bus),
        .mem            (mem_bus),
        .conflict_count (conflict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    grant_t      exp_grant[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] last_d = 32'h0;
    int          mem_lat = 1;
    bit          mem_manual = 1'b0;
    int          last_busy_len = 0;
    int          last_i_cyc = 0;
    int          i_pulses = 0;
    int          d_pulses = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = mem_read(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        end
        mem_arr[a] = v;
    endfunction

    // Memory model: ready after mem_lat cycles of mem_req, driven at negedge.
    initial begin
        int busy_n;
        busy_n = 0;
        mem_bus.ready = 1'b0;
        mem_bus.rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            if (mem_manual) begin
                busy_n = 0;
            end else if (mem_bus.req === 1'b1) begin
                busy_n++;
                if (busy_n == mem_lat) begin
                    mem_bus.ready = 1'b1;
                    mem_bus.rdata = mem_read(mem_bus.addr);
                    if (mem_bus.we) mem_write(mem_bus.addr, mem_bus.wdata, mem_bus.wstrb);
                end else begin
                    mem_bus.ready = 1'b0;
                    mem_bus.rdata = 32'hBAD0_BAD0;
                end
            end else begin
                busy_n = 0;
                mem_bus.ready = 1'b0;
                mem_bus.rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Grant monitor: new mem_req checked against the grant scoreboard, then held stable.
    initial begin
        grant_t cur;
        bit     prev_req;
        int     blen;
        prev_req = 1'b0;
        blen = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.req === 1'b1) begin
                if (!prev_req) begin
                    cur = {mem_bus.addr, mem_bus.wdata, mem_bus.wstrb, mem_bus.we};
                    blen = 1;
                    if (exp_grant.size() == 0) check("grant_unexpected", 0, 1);
                    else check("grant", cur, exp_grant.pop_front());
                end else begin
                    blen++;
                    check("hold", {mem_bus.addr, mem_bus.wdata, mem_bus.wstrb, mem_bus.we}, cur);
                end
            end else if (prev_req) begin
                last_busy_len = blen;
            end
            prev_req = (mem_bus.req === 1'b1);
        end
    end

    // Completion monitor: each ready pulse is one cycle wide and carries the expected word.
    initial begin
        bit i_prev;
        bit d_prev;
        i_prev = 1'b0;
        d_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (imem_bus.ready === 1'b1) begin
                i_pulses++;
                check("imem_pulse_width", i_prev, 0);
                if (exp_i.size() == 0) check("imem_unexpected", 0, 1);
                else check("imem_data", imem_bus.rdata, exp_i.pop_front());
            end
            if (dmem_bus.ready === 1'b1) begin
                d_pulses++;
                check("dmem_pulse_width", d_prev, 0);
                if (exp_d.size() == 0) check("dmem_unexpected", 0, 1);
                else check("dmem_rdata", dmem_bus.rdata, exp_d.pop_front());
            end
            i_prev = (imem_bus.ready === 1'b1);
            d_prev = (dmem_bus.ready === 1'b1);
        end
    end

    // Fetch agent: n consecutive fetches, request held high between them.
    task automatic run_fetch(input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            int cyc;
            cyc = 0;
            imem_bus.req  = 1'b1;
            imem_bus.addr = base + 32'(4 * k);
            exp_i.push_back(mem_read(imem_bus.addr));
            do begin
                @(negedge clk);
                cyc++;
            end while (imem_bus.ready !== 1'b1 && cyc < 200);
            if (imem_bus.ready !== 1'b1) check("imem_timeout", cyc, 0);
            last_i_cyc = cyc;
        end
        imem_bus.req = 1'b0;
    endtask

    // Data agent: n consecutive loads or stores at word-stepped addresses.
    task automatic run_data(input int n, input logic [31:0] base, input logic we,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        for (int k = 0; k < n; k++) begin
            int cyc;
            cyc = 0;
            dmem_bus.req   = 1'b1;
            dmem_bus.addr  = base + 32'(4 * k);
            dmem_bus.we    = we;
            dmem_bus.wdata = wdata;
            dmem_bus.wstrb = wstrb;
            if (!we) last_d = mem_read(dmem_bus.addr);
            exp_d.push_back(last_d);
            do begin
                @(negedge clk);
                cyc++;
            end while (dmem_bus.ready !== 1'b1 && cyc < 200);
            if (dmem_bus.ready !== 1'b1) check("dmem_timeout", cyc, 0);
        end
        dmem_bus.req = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_data"}, imem_bus.rdata, NOP_INSTR);
        check({tag, "_dmem_rdata"}, dmem_bus.rdata, 32'h0);
        check({tag, "_readys"}, {imem_bus.ready, dmem_bus.ready}, 2'b00);
        check({tag, "_mem_req_we"}, {mem_bus.req, mem_bus.we}, 2'b00);
        check({tag, "_mem_fields"}, {mem_bus.addr, mem_bus.wdata, mem_bus.wstrb}, 68'h0);
        check({tag, "_conflict"}, conflict_count, 32'h0);
        check({tag, "_state"}, u_dut.state_q, IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_word;
        int          di;
        int          ii;
        int          d_before;

        rst_n = 1'b0;
        imem_bus.req   = 1'b0;
        imem_bus.addr  = '0;
        // The fetch port's write fields carry junk; grants must zero them.
        imem_bus.wdata = 32'hFFFF_FFFF;
        imem_bus.wstrb = 4'hF;
        imem_bus.we    = 1'b1;
        dmem_bus.req   = 1'b0;
        dmem_bus.addr  = '0;
        dmem_bus.wdata = '0;
        dmem_bus.wstrb = '0;
        dmem_bus.we    = 1'b0;
        mem_arr[32'h1000] = 32'h0050_0093;

        // Reset state, during and after reset.
        repeat (3) @(negedge clk);
        check_reset_values("rst_in");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("rst_out");

        // Single fetch with zero-wait memory: IDLE, BUSY, RESP.
        mem_lat = 1;
        exp_grant.push_back('{addr: 32'h1000, wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        run_fetch(1, 32'h1000);
        check("fetch_cycles", last_i_cyc + 1, 3);
        check("fetch_imem_data", imem_bus.rdata, 32'h0050_0093);
        check("fetch_busy_len", last_busy_len, 1);
        repeat (2) @(negedge clk);

        // Both requesters held: D,D,D,D,I,D,D,D,D,I then a lone D.
        di = 0;
        ii = 0;
        for (int g = 0; g < 11; g++) begin
            if (g == 4 || g == 9) begin
                exp_grant.push_back('{addr: 32'h1100 + 32'(4 * ii), wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
                ii++;
            end else begin
                exp_grant.push_back('{addr: 32'h3000 + 32'(4 * di), wdata: 32'h1234_5678, wstrb: 4'h0, we: 1'b0});
                di++;
            end
        end
        fork
            run_fetch(2, 32'h1100);
            run_data(9, 32'h3000, 1'b0, 32'h1234_5678, 4'h0);
        join
        check("contend_conflicts", conflict_count, 32'd10);
        check("contend_starve", u_dut.u_starve.starve_cnt, 4'd0);
        check("contend_grants_left", exp_grant.size(), 0);
        repeat (2) @(negedge clk);

        // Store with 5-cycle latency; dmem_rdata keeps the previous load value.
        mem_lat  = 5;
        old_word = mem_read(32'h2004);
        d_before = d_pulses;
        exp_grant.push_back('{addr: 32'h2004, wdata: 32'hDEAD_BEEF, wstrb: 4'b1100, we: 1'b1});
        run_data(1, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'b1100);
        check("store_busy_len", last_busy_len, 5);
        check("store_rdata_kept", dmem_bus.rdata, 32'h3000 ^ 32'h5A5A_5A5A ^ 32'h20);
        check("store_one_pulse", d_pulses, d_before + 1);
        repeat (2) @(negedge clk);

        // Read back: only the strobed upper bytes changed.
        mem_lat = 1;
        exp_grant.push_back('{addr: 32'h2004, wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        run_data(1, 32'h2004, 1'b0, 32'h0, 4'h0);
        check("store_merge", dmem_bus.rdata, {16'hDEAD, old_word[15:0]});
        repeat (2) @(negedge clk);

        // Reset in BUSY_D with completion pending: abandon, ignore late ready.
        mem_lat  = 1000;
        d_before = d_pulses;
        exp_grant.push_back('{addr: 32'h4000, wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        dmem_bus.req   = 1'b1;
        dmem_bus.addr  = 32'h4000;
        dmem_bus.we    = 1'b0;
        dmem_bus.wdata = 32'h0;
        dmem_bus.wstrb = 4'h0;
        for (int k = 0; k < 10 && mem_bus.req !== 1'b1; k++) @(negedge clk);
        check("abort_mem_req_seen", mem_bus.req, 1'b1);
        check("abort_state_busy_d", u_dut.state_q, BUSY_D);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_mem_req_drop", mem_bus.req, 1'b0);
        check("abort_no_ready", dmem_bus.ready, 1'b0);
        dmem_bus.req = 1'b0;
        exp_d.delete();
        last_d = 32'h0;
        @(negedge clk);
        check_reset_values("abort");
        rst_n = 1'b1;
        @(negedge clk);
        mem_manual    = 1'b1;
        mem_bus.ready = 1'b1;
        mem_bus.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_bus.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("late_ready_state", u_dut.state_q, IDLE);
        check("late_ready_mem_req", mem_bus.req, 1'b0);
        check("late_ready_rdata", dmem_bus.rdata, 32'h0);
        check("late_ready_no_pulse", d_pulses, d_before);
        mem_manual = 1'b0;

        // Ten fetches only, 2-cycle memory: no starvation, no conflicts.
        mem_lat = 2;
        for (int k = 0; k < 10; k++) begin
            exp_grant.push_back('{addr: 32'h8000 + 32'(4 * k), wdata: 32'h0, wstrb: 4'h0, we: 1'b0});
        end
        run_fetch(10, 32'h8000);
        check("fetch_only_cycles", last_i_cyc, 4);
        check("fetch_only_starve", u_dut.u_starve.starve_cnt, 4'd0);
        check("fetch_only_conflict", conflict_count, 32'd0);
        repeat (3) @(negedge clk);

        check("total_imem_pulses", i_pulses, 13);
        check("total_dmem_pulses", d_pulses, 11);
        check("left_grants", exp_grant.size(), 0);
        check("left_imem", exp_i.size(), 0);
        check("left_dmem", exp_d.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
